// File: rtl/cai_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cai_host_pkg
// Description : Shared types and constants for the CAI host submit/retire ring.
// Revision    : 1.0 - initial release
// ============================================================================
package cai_host_pkg;

    // Submit sequencer states: grant, descriptor write, doorbell high, doorbell low
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_BELL_HI = 2'd2,
        ST_BELL_LO = 2'd3
    } submit_state_t;

    // Status reported for a job retired by the watchdog
    localparam logic [15:0] C_TIMEOUT_STATUS = 16'hFFFF;

    // Index width for n items, never below one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cai_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cai_tag_fifo
// Description : In-order retire FIFO holding {tag, channel} per submitted job.
//               Head is visible combinationally; push and pop may coincide.
// Revision    : 1.0 - initial release
// ============================================================================
module cai_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cai_host_ring.sv
`default_nettype none
// ============================================================================
// Module      : cai_host_ring
// Description : Host side of the CAI submit/completion ring. Arbitrates
//               requester channels, writes descriptors, rings the doorbell,
//               retires completions in order and watches for stalled jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module cai_host_ring
    import cai_host_pkg::*;
#(
    parameter int               NUM_CH         = 2,
    parameter int               RING_DEPTH     = 4,
    parameter int               TIMEOUT_CYCLES = 20000,
    parameter int               TAG_W          = 32,
    parameter logic [TAG_W-1:0] TAG_INIT       = TAG_W'(1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CH-1:0]                    ch_req_valid,
    output logic [NUM_CH-1:0]                    ch_req_ready,
    output logic                                 sub_wr_valid,
    output logic [clog2_min1(RING_DEPTH)-1:0]    sub_wr_slot,
    output logic [TAG_W-1:0]                     sub_wr_tag,
    output logic [clog2_min1(NUM_CH)-1:0]        sub_wr_ch,
    input  logic                                 sub_wr_done,
    output logic                                 submit_doorbell,
    input  logic                                 comp_valid,
    input  logic [TAG_W-1:0]                     comp_tag,
    input  logic [15:0]                          comp_status,
    output logic                                 done_valid,
    output logic [clog2_min1(NUM_CH)-1:0]        done_ch,
    output logic [TAG_W-1:0]                     done_tag,
    output logic [15:0]                          done_status,
    output logic [$clog2(RING_DEPTH):0]          outstanding,
    output logic                                 err_tag,
    output logic                                 err_timeout,
    output logic                                 err_spurious,
    input  logic                                 err_clr
);

    localparam int SLOT_W = clog2_min1(RING_DEPTH);
    localparam int CH_W   = clog2_min1(NUM_CH);
    localparam int CNT_W  = $clog2(RING_DEPTH) + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ENT_W  = TAG_W + CH_W;

    submit_state_t     r_state;
    submit_state_t     w_state_nxt;

    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   w_cand;
    logic [CH_W-1:0]   w_grant_ch;
    logic              w_found;
    logic              w_grant_en;
    logic              w_accept;

    logic [TAG_W-1:0]  r_tag;
    logic [TAG_W-1:0]  r_wr_tag;
    logic [CH_W-1:0]   r_wr_ch;
    logic [SLOT_W-1:0] r_submit_idx;
    logic [SLOT_W-1:0] r_wr_slot;
    logic [CNT_W-1:0]  r_outstanding;
    logic [TO_W-1:0]   r_to_cnt;

    logic              r_err_tag;
    logic              r_err_timeout;
    logic              r_err_spurious;
    logic              w_err_any;

    logic              r_done_valid;
    logic [CH_W-1:0]   r_done_ch;
    logic [TAG_W-1:0]  r_done_tag;
    logic [15:0]       r_done_status;

    logic [ENT_W-1:0]  w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [TAG_W-1:0]  w_head_tag;
    logic [CH_W-1:0]   w_head_ch;
    logic              w_comp_retire;
    logic              w_spurious;
    logic              w_to_fire;
    logic              w_retire;
    logic              w_tag_mismatch;

    assign w_err_any  = r_err_tag | r_err_timeout | r_err_spurious;
    // Grants need an idle sequencer, a free ring slot and a clean error state
    assign w_grant_en = (r_state == ST_IDLE) && !rst && !w_err_any && !w_fifo_full;
    assign w_accept   = w_found;

    assign w_head_tag     = w_fifo_head[ENT_W-1:CH_W];
    assign w_head_ch      = w_fifo_head[CH_W-1:0];
    assign w_comp_retire  = comp_valid && !w_fifo_empty;
    assign w_spurious     = comp_valid && w_fifo_empty;
    assign w_to_fire      = !comp_valid && !w_fifo_empty && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_retire       = w_comp_retire || w_to_fire;
    assign w_tag_mismatch = w_comp_retire && (comp_tag != w_head_tag);

    assign sub_wr_slot  = r_wr_slot;
    assign sub_wr_tag   = r_wr_tag;
    assign sub_wr_ch    = r_wr_ch;
    assign done_valid   = r_done_valid;
    assign done_ch      = r_done_ch;
    assign done_tag     = r_done_tag;
    assign done_status  = r_done_status;
    assign outstanding  = r_outstanding;
    assign err_tag      = r_err_tag;
    assign err_timeout  = r_err_timeout;
    assign err_spurious = r_err_spurious;

    // Round-robin search starting at the channel after the last grant
    always_comb begin
        ch_req_ready = '0;
        w_grant_ch   = '0;
        w_found      = 1'b0;
        w_cand       = '0;
        if (w_grant_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_cand = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
                if (!w_found && ch_req_valid[w_cand]) begin
                    w_found    = 1'b1;
                    w_grant_ch = w_cand;
                end
            end
            if (w_found) begin
                ch_req_ready[w_grant_ch] = 1'b1;
            end
        end
    end

    // Submit sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Submit sequencer next state and write/doorbell strobes
    always_comb begin
        w_state_nxt     = r_state;
        sub_wr_valid    = 1'b0;
        submit_doorbell = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                sub_wr_valid = 1'b1;
                if (sub_wr_done) begin
                    w_state_nxt = ST_BELL_HI;
                end
            end
            ST_BELL_HI: begin
                submit_doorbell = 1'b1;
                w_state_nxt     = ST_BELL_LO;
            end
            ST_BELL_LO: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch descriptor fields and advance tag, slot index and arbitration on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag        <= TAG_INIT;
            r_wr_tag     <= '0;
            r_wr_ch      <= '0;
            r_wr_slot    <= '0;
            r_submit_idx <= '0;
            r_rr_ptr     <= '0;
        end else if (w_accept) begin
            r_wr_tag     <= r_tag;
            r_wr_ch      <= w_grant_ch;
            r_wr_slot    <= r_submit_idx;
            r_submit_idx <= (r_submit_idx == SLOT_W'(RING_DEPTH - 1)) ? '0 : r_submit_idx + SLOT_W'(1);
            // Tag zero is reserved, so the counter wraps from all-ones to one
            r_tag        <= (r_tag == '1) ? TAG_W'(1) : r_tag + TAG_W'(1);
            r_rr_ptr     <= (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + CH_W'(1);
        end
    end

    // Outstanding job count: accept and retire in the same cycle cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Watchdog: counts consecutive cycles with work pending and no completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (comp_valid || w_fifo_empty || w_to_fire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Retire pulse one cycle after the head leaves the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_valid  <= 1'b0;
            r_done_ch     <= '0;
            r_done_tag    <= '0;
            r_done_status <= '0;
        end else begin
            r_done_valid <= w_retire;
            if (w_retire) begin
                r_done_ch     <= w_head_ch;
                r_done_tag    <= w_head_tag;
                r_done_status <= w_comp_retire ? comp_status : C_TIMEOUT_STATUS;
            end
        end
    end

    // Sticky error flags; clearing wins over a simultaneous set
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_err_tag      <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_err_tag      <= r_err_tag      | w_tag_mismatch;
            r_err_timeout  <= r_err_timeout  | w_to_fire;
            r_err_spurious <= r_err_spurious | w_spurious;
        end
    end

    cai_tag_fifo #(
        .DEPTH (RING_DEPTH),
        .WIDTH (ENT_W)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_data ({r_tag, w_grant_ch}),
        .i_pop       (w_retire),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_cai_host_ring.sv
`default_nettype none
// ============================================================================
// Module      : tb_cai_host_ring
// Description : Self-checking bench for cai_host_ring: directed scenarios with
//               literal expectations plus a randomized run against a
//               queue-based reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cai_host_ring;

    localparam int NUM_CH  = 2;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ch_req_valid = '0;
    logic [1:0]  ch_req_ready;
    logic        sub_wr_valid;
    logic [1:0]  sub_wr_slot;
    logic [31:0] sub_wr_tag;
    logic [0:0]  sub_wr_ch;
    logic        sub_wr_done = 1'b0;
    logic        submit_doorbell;
    logic        comp_valid = 1'b0;
    logic [31:0] comp_tag = '0;
    logic [15:0] comp_status = '0;
    logic        done_valid;
    logic [0:0]  done_ch;
    logic [31:0] done_tag;
    logic [15:0] done_status;
    logic [2:0]  outstanding;
    logic        err_tag, err_timeout, err_spurious;
    logic        err_clr = 1'b0;

    // Second instance starting its tag counter at all-ones
    logic        w_rst = 1'b1;
    logic [1:0]  w_valid = '0;
    logic [1:0]  w_ready;
    logic        w_wr_valid;
    logic [1:0]  w_wr_slot;
    logic [31:0] w_wr_tag;
    logic [0:0]  w_wr_ch;
    logic        w_wr_done = 1'b0;
    logic        w_bell;
    logic        w_done_valid;
    logic [0:0]  w_done_ch;
    logic [31:0] w_done_tag;
    logic [15:0] w_done_status;
    logic [2:0]  w_outstanding;
    logic        w_et, w_eto, w_es;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cai_host_ring #(.NUM_CH(NUM_CH), .RING_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .sub_wr_valid(sub_wr_valid), .sub_wr_slot(sub_wr_slot), .sub_wr_tag(sub_wr_tag),
        .sub_wr_ch(sub_wr_ch), .sub_wr_done(sub_wr_done), .submit_doorbell(submit_doorbell),
        .comp_valid(comp_valid), .comp_tag(comp_tag), .comp_status(comp_status),
        .done_valid(done_valid), .done_ch(done_ch), .done_tag(done_tag), .done_status(done_status),
        .outstanding(outstanding), .err_tag(err_tag), .err_timeout(err_timeout),
        .err_spurious(err_spurious), .err_clr(err_clr)
    );

    cai_host_ring #(.NUM_CH(NUM_CH), .RING_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .TAG_W(32),
                    .TAG_INIT(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst(w_rst), .ch_req_valid(w_valid), .ch_req_ready(w_ready),
        .sub_wr_valid(w_wr_valid), .sub_wr_slot(w_wr_slot), .sub_wr_tag(w_wr_tag),
        .sub_wr_ch(w_wr_ch), .sub_wr_done(w_wr_done), .submit_doorbell(w_bell),
        .comp_valid(1'b0), .comp_tag(32'd0), .comp_status(16'd0),
        .done_valid(w_done_valid), .done_ch(w_done_ch), .done_tag(w_done_tag),
        .done_status(w_done_status), .outstanding(w_outstanding), .err_tag(w_et),
        .err_timeout(w_eto), .err_spurious(w_es), .err_clr(1'b0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q_tag [$];
    int          q_ch  [$];
    logic        m_valid = 1'b0;
    int          m_phase;          // 0 idle, 1 writing, 2 doorbell high, 3 doorbell low
    logic [31:0] m_tag, m_wtag, m_dtag;
    int          m_idx, m_next, m_to, m_slot, m_wch, m_dch;
    logic [15:0] m_dst;
    logic        m_dv, m_et, m_eto, m_es;

    // Per-cycle compare of every output, then advance the model past the next edge
    always @(negedge clk) begin
        int g;
        int c;
        int sz;
        logic [1:0] exp_ready;
        logic s_tag, s_sp, s_to;
        if (rst) begin
            q_tag.delete(); q_ch.delete();
            m_valid = 1'b1; m_phase = 0; m_tag = 32'd1; m_wtag = '0; m_dtag = '0;
            m_idx = 0; m_next = 0; m_to = 0; m_slot = 0; m_wch = 0; m_dch = 0;
            m_dst = '0; m_dv = 0; m_et = 0; m_eto = 0; m_es = 0;
        end else if (m_valid) begin
            g = -1;
            exp_ready = '0;
            if (m_phase == 0 && q_tag.size() < DEPTH && !(m_et || m_eto || m_es)) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m_next + k) % NUM_CH;
                    if (g < 0 && ch_req_valid[c[0]]) g = c;
                end
            end
            if (g >= 0) exp_ready[g[0]] = 1'b1;
            check("ready", 64'(ch_req_ready), 64'(exp_ready));
            check("sub_wr_valid", 64'(sub_wr_valid), 64'(m_phase == 1));
            if (m_phase == 1) begin
                check("sub_wr_slot", 64'(sub_wr_slot), 64'(m_slot));
                check("sub_wr_tag", 64'(sub_wr_tag), 64'(m_wtag));
                check("sub_wr_ch", 64'(sub_wr_ch), 64'(m_wch));
            end
            check("doorbell", 64'(submit_doorbell), 64'(m_phase == 2));
            check("done_valid", 64'(done_valid), 64'(m_dv));
            if (m_dv) begin
                check("done_ch", 64'(done_ch), 64'(m_dch));
                check("done_tag", 64'(done_tag), 64'(m_dtag));
                check("done_status", 64'(done_status), 64'(m_dst));
            end
            check("outstanding", 64'(outstanding), 64'(q_tag.size()));
            check("err_tag", 64'(err_tag), 64'(m_et));
            check("err_timeout", 64'(err_timeout), 64'(m_eto));
            check("err_spurious", 64'(err_spurious), 64'(m_es));

            // advance: retire side uses occupancy before this cycle's accept
            sz = q_tag.size();
            s_tag = 0; s_sp = 0; s_to = 0; m_dv = 0;
            if (comp_valid) begin
                m_to = 0;
                if (sz > 0) begin
                    m_dv = 1; m_dtag = q_tag[0]; m_dch = q_ch[0]; m_dst = comp_status;
                    s_tag = (comp_tag != q_tag[0]);
                    void'(q_tag.pop_front()); void'(q_ch.pop_front());
                end else begin
                    s_sp = 1;
                end
            end else if (sz == 0) begin
                m_to = 0;
            end else begin
                m_to = m_to + 1;
                if (m_to == TIMEOUT) begin
                    m_to = 0; s_to = 1;
                    m_dv = 1; m_dtag = q_tag[0]; m_dch = q_ch[0]; m_dst = 16'hFFFF;
                    void'(q_tag.pop_front()); void'(q_ch.pop_front());
                end
            end
            if (g >= 0) begin
                q_tag.push_back(m_tag); q_ch.push_back(g);
                m_wtag = m_tag; m_wch = g; m_slot = m_idx % DEPTH; m_idx++;
                m_tag = (m_tag == 32'hFFFF_FFFF) ? 32'd1 : m_tag + 32'd1;
                m_next = (g + 1) % NUM_CH;
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (sub_wr_done) m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 3;
            end else if (m_phase == 3) begin
                m_phase = 0;
            end
            if (err_clr) begin
                m_et = 0; m_eto = 0; m_es = 0;
            end else begin
                m_et = m_et | s_tag; m_eto = m_eto | s_to; m_es = m_es | s_sp;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ch_req_valid = '0; comp_valid = 1'b0; err_clr = 1'b0; sub_wr_done = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  grants [8];
        int          slots  [8];
        logic [31:0] wtags  [4];
        int na, ns, nw, cyc;
        logic found;

        step(); step();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_ready", 64'(ch_req_ready), 64'd0);
        check("rst_sub_wr_valid", 64'(sub_wr_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_errs", 64'({err_tag, err_timeout, err_spurious}), 64'd0);

        // Single job on ch0: slot 0, tag 1, one-cycle doorbell, clean retire
        step(); ch_req_valid = 2'b01;
        @(negedge clk); check("t1_grant", 64'(ch_req_ready), 64'h1);
        step(); ch_req_valid = 2'b00; sub_wr_done = 1'b1;
        @(negedge clk);
        check("t1_wr_valid", 64'(sub_wr_valid), 64'd1);
        check("t1_slot", 64'(sub_wr_slot), 64'd0);
        check("t1_tag", 64'(sub_wr_tag), 64'd1);
        check("t1_ch", 64'(sub_wr_ch), 64'd0);
        step(); sub_wr_done = 1'b0;
        @(negedge clk); check("t1_bell_hi", 64'(submit_doorbell), 64'd1);
        step(); comp_valid = 1'b1; comp_tag = 32'd1; comp_status = 16'h0000;
        @(negedge clk); check("t1_bell_lo", 64'(submit_doorbell), 64'd0);
        step(); comp_valid = 1'b0;
        @(negedge clk);
        check("t1_done_valid", 64'(done_valid), 64'd1);
        check("t1_done_ch", 64'(done_ch), 64'd0);
        check("t1_done_tag", 64'(done_tag), 64'd1);
        check("t1_done_status", 64'(done_status), 64'd0);
        check("t1_outstanding", 64'(outstanding), 64'd0);

        // Both channels requesting, completions withheld: alternate grants, ring fills
        step(); do_reset();
        ch_req_valid = 2'b11; sub_wr_done = 1'b1;
        na = 0; ns = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if ((ch_req_valid & ch_req_ready) != 2'b00 && na < 8) begin
                grants[na] = ch_req_ready; na++;
            end
            if (sub_wr_valid && ns < 8) begin
                slots[ns] = int'(sub_wr_slot); ns++;
            end
            step();
        end
        @(negedge clk);
        check("t2_accepts", 64'(na), 64'd4);
        check("t2_outstanding", 64'(outstanding), 64'd4);
        check("t2_ready_low", 64'(ch_req_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t2_grant", 64'(grants[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
            check("t2_slot", 64'(slots[i]), 64'(i));
        end

        // Tag mismatch: head still retires, grants blocked until err_clr
        step(); do_reset();
        ch_req_valid = 2'b01;
        @(negedge clk);
        step(); ch_req_valid = 2'b00; sub_wr_done = 1'b1;
        step(); sub_wr_done = 1'b0;
        step(); comp_valid = 1'b1; comp_tag = 32'd5; comp_status = 16'h1234;
        step(); comp_valid = 1'b0; ch_req_valid = 2'b11;
        @(negedge clk);
        check("t3_done_valid", 64'(done_valid), 64'd1);
        check("t3_done_tag", 64'(done_tag), 64'd1);
        check("t3_err_tag", 64'(err_tag), 64'd1);
        check("t3_blocked", 64'(ch_req_ready), 64'd0);
        step(); err_clr = 1'b1;
        @(negedge clk); check("t3_blocked_clr", 64'(ch_req_ready), 64'd0);
        step(); err_clr = 1'b0;
        @(negedge clk);
        check("t3_err_cleared", 64'(err_tag), 64'd0);
        check("t3_resume", 64'(ch_req_ready), 64'h2);

        // Watchdog retire of a single stalled job
        step(); do_reset();
        ch_req_valid = 2'b01;
        @(negedge clk);
        step(); ch_req_valid = 2'b00; sub_wr_done = 1'b1;
        cyc = 1; found = 1'b0;
        @(negedge clk);
        found = done_valid;
        while (!found && cyc < 40) begin
            step(); cyc++;
            @(negedge clk);
            found = done_valid;
        end
        check("t4_seen", 64'(found), 64'd1);
        check("t4_latency", 64'(cyc), 64'd17);
        check("t4_status", 64'(done_status), 64'hFFFF);
        check("t4_err_timeout", 64'(err_timeout), 64'd1);

        // Spurious completion, then reset in the middle of a write
        step(); do_reset();
        comp_valid = 1'b1; comp_tag = 32'd1;
        step(); comp_valid = 1'b0;
        @(negedge clk);
        check("t5_err_spurious", 64'(err_spurious), 64'd1);
        check("t5_no_done", 64'(done_valid), 64'd0);
        step(); err_clr = 1'b1;
        step(); err_clr = 1'b0; ch_req_valid = 2'b01;
        @(negedge clk); check("t5_grant", 64'(ch_req_ready), 64'h1);
        step(); ch_req_valid = 2'b00;
        @(negedge clk); check("t5_in_write", 64'(sub_wr_valid), 64'd1);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check("t5_rst_outs", 64'({ch_req_ready, sub_wr_valid, sub_wr_slot, sub_wr_ch, submit_doorbell,
                                  done_valid, done_ch, outstanding, err_tag, err_timeout, err_spurious}), 64'd0);
        check("t5_rst_tags", 64'({sub_wr_tag, done_tag}), 64'd0);
        check("t5_rst_status", 64'(done_status), 64'd0);
        step(); ch_req_valid = 2'b01;
        @(negedge clk);
        step(); ch_req_valid = 2'b00;
        @(negedge clk); check("t5_tag_restart", 64'(sub_wr_tag), 64'd1);

        // Randomized traffic against the model
        step(); do_reset();
        for (int i = 0; i < 3000; i++) begin
            ch_req_valid = 2'($urandom);
            sub_wr_done  = ($urandom % 100) < 60;
            comp_valid   = ($urandom % 100) < 12;
            comp_tag     = (q_tag.size() > 0 && ($urandom % 10) != 0) ? q_tag[0] : $urandom;
            comp_status  = 16'($urandom);
            err_clr      = ($urandom % 100) < 4;
            rst          = ($urandom % 1000) < 3;
            step();
        end
        ch_req_valid = '0; comp_valid = 1'b0; err_clr = 1'b0; rst = 1'b0;

        // Tag counter wrap from all-ones
        w_rst = 1'b0; w_valid = 2'b01; w_wr_done = 1'b1;
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (w_wr_valid && nw < 4) begin
                wtags[nw] = w_wr_tag; nw++;
            end
            step();
        end
        check("t6_writes", 64'(nw >= 2), 64'd1);
        check("t6_tag0", 64'(wtags[0]), 64'hFFFF_FFFF);
        check("t6_tag1", 64'(wtags[1]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
